// File: rtl/debounce_pulse_pkg.sv
// Shared constant helpers for the counter-path blocks.
package debounce_pulse_pkg;

    // Number of address bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // Largest of three integers.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/debounce_pulse_sync_ff.sv
// Parameterised multi-flop synchronizer with asynchronous clear to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Button conditioner: synchronizes and debounces a raw input, then emits
// single-cycle incr pulses per press and per auto-repeat, plus a release pulse.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int N_SYNC          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic incr,
    output logic level,
    output logic rel,
    output logic rpt_active
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_incr, pulse_rel;
    logic             btn_norm;
    logic             s;

    // Pressed is always 1 from here on, whatever the button wiring.
    assign btn_norm = (ACTIVE_HIGH != 0) ? btn_in : ~btn_in;

    sync_ff #(
        .STAGES (N_SYNC)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_norm),
        .q     (s)
    );

    // Next-state, shared counter and pulse decode; cnt clears on every state change.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pulse_incr = 1'b0;
        pulse_rel  = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = HELD;
                    cnt_nxt    = '0;
                    pulse_incr = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    cnt_nxt = '0;
                end else if (cnt == DLY_LAST) begin
                    state_nxt  = REPEAT;
                    cnt_nxt    = '0;
                    pulse_incr = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                // A release seen in the same cycle a repeat falls due wins.
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == RATE_LAST) begin
                    cnt_nxt    = '0;
                    pulse_incr = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pulse_rel = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            incr       <= 1'b0;
            rel        <= 1'b0;
            level      <= 1'b0;
            rpt_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            incr       <= pulse_incr;
            rel        <= pulse_rel;
            level      <= (state_nxt == HELD) || (state_nxt == REPEAT) ||
                          (state_nxt == RELEASE_WAIT);
            rpt_active <= (state_nxt == REPEAT);
        end
    end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: directed scenarios plus random button activity,
// checked against a run-length based behavioural model. A second instance
// with inverted polarity sees the complemented button and must match too.
module tb_debounce_pulse;

    localparam int N_SYNC = 2;
    localparam int DEB    = 4;
    localparam int RDLY   = 8;
    localparam int RRATE  = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic btn_n;
    logic repeat_en;
    logic incr_h, level_h, rel_h, rpt_h;
    logic incr_l, level_l, rel_l, rpt_l;

    assign btn_n = ~btn;

    always #5 clk = ~clk;

    debounce_pulse #(
        .N_SYNC(N_SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY),
        .REPEAT_RATE(RRATE), .ACTIVE_HIGH(1)
    ) dut_hi (
        .clk(clk), .reset(reset), .btn_in(btn), .repeat_en(repeat_en),
        .incr(incr_h), .level(level_h), .rel(rel_h), .rpt_active(rpt_h)
    );

    debounce_pulse #(
        .N_SYNC(N_SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY),
        .REPEAT_RATE(RRATE), .ACTIVE_HIGH(0)
    ) dut_lo (
        .clk(clk), .reset(reset), .btn_in(btn_n), .repeat_en(repeat_en),
        .incr(incr_l), .level(level_l), .rel(rel_l), .rpt_active(rpt_l)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit hist[N_SYNC];
    bit m_down, m_rep, m_prev;
    int m_run, m_tmr;
    bit e_incr, e_level, e_rel, e_rpt;

    // Bookkeeping for directed checks.
    int cyc = 0;
    int first_incr_cyc;
    int first_rel_cyc;
    int incr_count;
    int rel_count;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_SYNC; i++) hist[i] = 1'b0;
        m_down = 0; m_rep = 0; m_prev = 0; m_run = 0; m_tmr = 0;
        e_incr = 0; e_level = 0; e_rel = 0; e_rpt = 0;
    endtask

    // One clock edge of the model: s is the button as it was N_SYNC edges ago;
    // a press or release is accepted after D+1 consecutive observations
    // (entering the wait state plus D stable cycles).
    task automatic model_edge(input bit b, input bit r);
        bit s_cur;
        bit ev_i, ev_r;
        s_cur = hist[N_SYNC-1];
        for (int i = N_SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = b;
        ev_i = 0;
        ev_r = 0;
        m_run = (s_cur == m_prev) ? m_run + 1 : 1;
        if (!m_down) begin
            if (s_cur && m_run == DEB + 1) begin
                m_down = 1; ev_i = 1; m_tmr = 0; m_rep = 0;
            end
        end else if (!s_cur) begin
            m_rep = 0;
            if (m_run == DEB + 1) begin
                m_down = 0; ev_r = 1;
            end
        end else if (!m_prev || !r) begin
            m_tmr = 0; m_rep = 0;
        end else begin
            m_tmr++;
            if (m_tmr == RDLY) begin
                ev_i = 1; m_rep = 1;
            end else if (m_tmr > RDLY && ((m_tmr - RDLY) % RRATE) == 0) begin
                ev_i = 1;
            end
        end
        m_prev  = s_cur;
        e_incr  = ev_i;
        e_rel   = ev_r;
        e_level = m_down;
        e_rpt   = m_rep;
    endtask

    task automatic step(input bit b, input bit r);
        btn = b;
        repeat_en = r;
        @(posedge clk);
        model_edge(b, r);
        cyc++;
        #1;
        check("outs_hi", int'({incr_h, level_h, rel_h, rpt_h}),
              int'({e_incr, e_level, e_rel, e_rpt}));
        check("outs_lo", int'({incr_l, level_l, rel_l, rpt_l}),
              int'({e_incr, e_level, e_rel, e_rpt}));
        if (incr_h) begin
            incr_count++;
            if (first_incr_cyc < 0) first_incr_cyc = cyc;
        end
        if (rel_h) begin
            rel_count++;
            if (first_rel_cyc < 0) first_rel_cyc = cyc;
        end
    endtask

    task automatic clear_marks();
        first_incr_cyc = -1;
        first_rel_cyc  = -1;
        incr_count     = 0;
        rel_count      = 0;
    endtask

    initial begin
        int c0;
        int seg_len;
        bit seg_b, seg_r;

        btn = 0;
        repeat_en = 0;
        reset = 1;
        model_reset();
        clear_marks();
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", int'({incr_h, level_h, rel_h, rpt_h}), 0);
        check("reset_lo", int'({incr_l, level_l, rel_l, rpt_l}), 0);
        #2 reset = 0;
        repeat (4) step(0, 0);

        // Clean press, then clean release; edges counted with the sampling edge as edge 1.
        clear_marks();
        c0 = cyc + 1;
        repeat (30) step(1, 0);
        check("press_latency", first_incr_cyc - c0 + 1, N_SYNC + DEB + 1);
        check("press_incr_count", incr_count, 1);
        check("press_level", int'(level_h), 1);
        c0 = cyc + 1;
        repeat (12) step(0, 0);
        check("release_latency", first_rel_cyc - c0 + 1, N_SYNC + DEB + 1);
        check("release_count", rel_count, 1);

        // Press bounce: toggling every 2 cycles never settles long enough.
        clear_marks();
        for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 0);
        repeat (10) step(0, 0);
        check("bounce_incr_count", incr_count, 0);
        check("bounce_level", int'(level_h), 0);

        // Auto-repeat: pulses at t0, t0+8, t0+11, t0+14, ...
        clear_marks();
        repeat (40) step(1, 1);
        check("repeat_incr_count", incr_count, 1 + 1 + (40 - 7 - RDLY) / RRATE);
        repeat (15) step(0, 1);

        // Release bounce while held.
        clear_marks();
        repeat (15) step(1, 0);
        repeat (2) step(0, 0);
        repeat (12) step(1, 0);
        check("relbounce_rel", rel_count, 0);
        check("relbounce_incr", incr_count, 1);
        check("relbounce_level", int'(level_h), 1);
        repeat (15) step(0, 0);

        // Reset mid-repeat with the button still held afterwards.
        repeat (25) step(1, 1);
        check("pre_reset_rpt", int'(rpt_h), 1);
        #2 reset = 1;
        #1;
        check("async_reset_hi", int'({incr_h, level_h, rel_h, rpt_h}), 0);
        check("async_reset_lo", int'({incr_l, level_l, rel_l, rpt_l}), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_hi", int'({incr_h, level_h, rel_h, rpt_h}), 0);
        #2 reset = 0;
        clear_marks();
        c0 = cyc + 1;
        repeat (12) step(1, 1);
        check("post_reset_latency", first_incr_cyc - c0 + 1, N_SYNC + DEB + 1);
        repeat (15) step(0, 0);

        // Random button activity with bursts of bounce and toggling repeat_en.
        for (int seg = 0; seg < 80; seg++) begin
            seg_b   = 1'($urandom_range(0, 1));
            seg_r   = 1'($urandom_range(0, 1));
            seg_len = (seg % 3 == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 30));
            for (int k = 0; k < seg_len; k++) begin
                step(seg_b, ($urandom_range(0, 9) == 0) ? ~seg_r : seg_r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Conditioning stage that sits directly upstream of the counter block. It takes a raw, asynchronous, bouncing push-button or switch input and produces clean single-cycle `incr` pulses to drive the counter. It also provides an optional hold-to-auto-repeat mode, a debounced level, and a release pulse. Everything runs in the counter's clock domain, so `incr` connects straight to the counter's `incr` input.

## Interface
- `N_SYNC`, 2: synchronizer depth in flops; must be ≥2.
- `DEBOUNCE_CYCLES`, 16: number of consecutive stable cycles required to accept a press or a release; must be ≥1.
- `REPEAT_DELAY`, 64: cycles from the first press pulse to the first repeat pulse; must be ≥1.
- `REPEAT_RATE`, 16: cycles between subsequent repeat pulses; must be ≥1.
- `ACTIVE_HIGH`, 1: 1 means btn_in=1 is pressed; 0 means btn_in=0 is pressed.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_in`  in  1  raw asynchronous button input, polarity per `ACTIVE_HIGH`.
- `repeat_en`  in  1  synchronous enable for auto-repeat; sampled every cycle.
- `incr`  out  1  one-cycle pulse per accepted press and per repeat.
- `level`  out  1  debounced pressed level.
- `rel`  out  1  one-cycle pulse on an accepted release.
- `rpt_active`  out  1  high while in the REPEAT state.

## Operation
- The raw input is normalised to active-high, then passed through the `N_SYNC`-stage synchronizer. All flops reset to 0. Call the last synchronizer stage `s`.
- One shared counter `cnt` has width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)), with a minimum of 1. It is cleared on every state change.
- The state machine has five states: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
  - **IDLE:** if s=1, go to PRESS_WAIT.
  - **PRESS_WAIT:** if s=0, return to IDLE (bounce rejected). If s=1 and cnt=DEBOUNCE_CYCLES-1, go to HELD and pulse `incr`. Otherwise increment cnt.
  - **HELD:** if s=0, go to RELEASE_WAIT. Else if repeat_en=1 and cnt=REPEAT_DELAY-1, go to REPEAT and pulse `incr`. Otherwise increment cnt. While repeat_en=0, cnt holds at 0.
  - **REPEAT:** if s=0, go to RELEASE_WAIT. Else if repeat_en=0, go to HELD with no pulse. Else if cnt=REPEAT_RATE-1, pulse `incr` and clear cnt. Otherwise increment cnt.
  - **RELEASE_WAIT:** if s=1, return to HELD with cnt=0 (release bounce rejected; no `incr`, no `rel`). If s=0 and cnt=DEBOUNCE_CYCLES-1, go to IDLE and pulse `rel`. Otherwise increment cnt.
- Outputs:
  - `level` is 1 in HELD, REPEAT and RELEASE_WAIT.
  - `rpt_active` is 1 in REPEAT only.
- Priority: the s=0 exit has priority over a repeat pulse falling due in the same cycle; no `incr` is issued in that cycle.
- `incr` and `rel` are never high in the same cycle, and neither is ever high for two consecutive cycles (`REPEAT_RATE`=1 is the exception: it gives continuous `incr`).

## Timing
- All outputs are registered and driven straight from flops. There is no combinational path from any input to any output.
- Reset values: `incr`=0, `level`=0, `rel`=0, `rpt_active`=0, state=IDLE, cnt=0, synchronizer=0.
- Press latency: a clean press gives `incr` high exactly N_SYNC+DEBOUNCE_CYCLES+1 posedges after the first posedge that samples btn_in active. `level` rises in the same cycle as `incr`.
- Release latency: `rel` and the fall of `level` occur N_SYNC+DEBOUNCE_CYCLES+1 posedges after the first posedge that samples btn_in inactive.
- Repeat timing, with t0 the cycle of the press `incr`:
  - First repeat pulse at t0+REPEAT_DELAY.
  - Then a pulse every REPEAT_RATE cycles.
- Reset asserted mid-operation, including mid-repeat, forces all outputs to 0 immediately (asynchronously). After deassertion, a still-held button must be re-debounced from IDLE.
- Any input glitch shorter than DEBOUNCE_CYCLES in the synchronized domain produces no output change.

## Structure
- No shared package is needed. State encodings are local localparams of this module (binary encoding).
- Add a clog2 constant function to the team's common header, so that other counter-path blocks can reuse it.
- One sub-module, `sync_ff`: a parameterised N-stage synchronizer with async reset to 0. It is instantiated once here and is reusable for other asynchronous inputs.

## Test plan
All scenarios use N_SYNC=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3 unless stated otherwise.
- **Clean press:** btn_in held active 30 cycles, repeat_en=0 -> exactly one `incr`, 7 edges after the first sample. `level` stays 1 until release; then `rel` appears 7 edges after release.
- **Press bounce:** btn_in toggles every 2 cycles for 20 cycles -> no `incr`, `level` stays 0, state returns to IDLE.
- **Auto-repeat:** held 40 cycles, repeat_en=1 -> `incr` at t0, t0+8, t0+11, t0+14, and so on. `rpt_active` is 1 from t0+8.
- **Release bounce:** while HELD, btn_in is inactive for 2 cycles then active again -> no `rel`, no extra `incr`, `level` stays 1.
- **Reset mid-repeat:** reset asserted while REPEAT -> all outputs 0 in the same cycle. With the button still held after deassertion, the next `incr` comes 7 edges after deassert.
- **Polarity:** ACTIVE_HIGH=0 with btn_in held at 0 -> same behaviour as the clean-press scenario.
